// File: rtl/datapath_with_memory_pkg.sv
// Purpose: shared widths, ALU op encoding and status bit positions for the datapath.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package datapath_with_memory_pkg;

    localparam int DATA_W     = 64;
    localparam int REG_ADDR_W = 5;
    localparam int FS_W       = 5;
    localparam int NUM_REGS   = 32;
    localparam int DBG_REGS   = 8;
    localparam int DBG_W      = 16;

    // FS[4:2]; encodings 6 and 7 produce a zero result.
    typedef enum logic [2:0] {
        FS_AND = 3'b000,
        FS_OR  = 3'b001,
        FS_ADD = 3'b010,
        FS_XOR = 3'b011,
        FS_SHL = 3'b100,
        FS_SHR = 3'b101
    } fs_op_e;

    // Bit positions within the {V,C,N,Z} status vector.
    localparam int ST_V = 3;
    localparam int ST_C = 2;
    localparam int ST_N = 1;
    localparam int ST_Z = 0;

endpackage

// File: rtl/datapath_with_memory_register_file.sv
// Purpose: 32x64 register file, two async read ports, R31 hardwired to zero.
// Latency: reads combinational; writes visible after the next rising edge.
// Backpressure: none; a write is accepted every cycle.
// Ports: clock/reset (sync, active-high), sa/sb read addresses -> ra/rb,
//        da/we/wr_dat write port, dbg_lo = low 16 bits of R0..R7.
module datapath_with_memory_register_file
    import datapath_with_memory_pkg::*;
(
    input  logic                           clock,
    input  logic                           reset,
    input  logic [REG_ADDR_W-1:0]          sa,
    input  logic [REG_ADDR_W-1:0]          sb,
    input  logic [REG_ADDR_W-1:0]          da,
    input  logic                           we,
    input  logic [DATA_W-1:0]              wr_dat,
    output logic [DATA_W-1:0]              ra,
    output logic [DATA_W-1:0]              rb,
    output logic [DBG_REGS-1:0][DBG_W-1:0] dbg_lo
);

    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;
    logic [NUM_REGS-1:0][DATA_W-1:0] regs_d;

    always_comb begin
        regs_d = regs_q;
        if (we) begin
            regs_d[da] = wr_dat;
        end
        // Entry 31 is kept at zero so the read ports need no special case.
        regs_d[NUM_REGS-1] = '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    assign ra = regs_q[sa];
    assign rb = regs_q[sb];

    always_comb begin
        dbg_lo = '0;
        for (int i = 0; i < DBG_REGS; i++) begin
            dbg_lo[i] = regs_q[i][DBG_W-1:0];
        end
    end

endmodule

// File: rtl/datapath_with_memory.sv
// Purpose: LEGv8-style execution core: register file, ALU, data RAM on a shared tri-state bus D.
// Latency: register->ALU->D/A/status and RAM->D are combinational; writes land on the next rising edge.
// Backpressure: none; the control unit sequences every cycle.
// Ports: clock, reset (sync, active-high); k/SA/SB/DA/W/selbork/FS/Cin datapath controls;
//        triSel* bus driver enables; writeEn/readEn RAM controls; D data bus; status {V,C,N,Z};
//        r0..r7 low 16 bits of R0..R7.
module datapath_with_memory
    import datapath_with_memory_pkg::*;
#(
    parameter int MEM_WORDS = 256
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     k,
    input  logic [REG_ADDR_W-1:0] SA,
    input  logic [REG_ADDR_W-1:0] SB,
    input  logic [REG_ADDR_W-1:0] DA,
    input  logic                  W,
    input  logic                  selbork,
    input  logic [FS_W-1:0]       FS,
    input  logic                  Cin,
    input  logic                  triSelBtoD,
    input  logic                  triSelFtoD,
    input  logic                  triSelFtoA,
    input  logic                  triSelOuttoD,
    input  logic                  writeEn,
    input  logic                  readEn,
    output logic [DATA_W-1:0]     D,
    output logic [3:0]            status,
    output logic [DBG_W-1:0]      r0,
    output logic [DBG_W-1:0]      r1,
    output logic [DBG_W-1:0]      r2,
    output logic [DBG_W-1:0]      r3,
    output logic [DBG_W-1:0]      r4,
    output logic [DBG_W-1:0]      r5,
    output logic [DBG_W-1:0]      r6,
    output logic [DBG_W-1:0]      r7
);

    localparam int MEM_ADDR_W = $clog2(MEM_WORDS);

    logic [DATA_W-1:0]              ra_dat;
    logic [DATA_W-1:0]              rb_dat;
    logic [DBG_REGS-1:0][DBG_W-1:0] dbg_lo;
    logic [DATA_W-1:0]              bus_dat;
    logic                           bus_vld;

    // The register file writes back whatever is on D; an undriven bus stores zero.
    datapath_with_memory_register_file u_regs (
        .clock  (clock),
        .reset  (reset),
        .sa     (SA),
        .sb     (SB),
        .da     (DA),
        .we     (W),
        .wr_dat (bus_dat),
        .ra     (ra_dat),
        .rb     (rb_dat),
        .dbg_lo (dbg_lo)
    );

    assign r0 = dbg_lo[0];
    assign r1 = dbg_lo[1];
    assign r2 = dbg_lo[2];
    assign r3 = dbg_lo[3];
    assign r4 = dbg_lo[4];
    assign r5 = dbg_lo[5];
    assign r6 = dbg_lo[6];
    assign r7 = dbg_lo[7];

    // ALU
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] add_sum;
    logic              add_c;
    logic [DATA_W-1:0] alu_f;
    logic              alu_c;
    logic              alu_v;

    always_comb begin
        alu_a = ra_dat ^ {DATA_W{FS[0]}};
        alu_b = (selbork ? k : rb_dat) ^ {DATA_W{FS[1]}};
        {add_c, add_sum} = {1'b0, alu_a} + {1'b0, alu_b} + {{DATA_W{1'b0}}, Cin};
        alu_f = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (FS[4:2])
            FS_AND: alu_f = alu_a & alu_b;
            FS_OR:  alu_f = alu_a | alu_b;
            FS_ADD: begin
                alu_f = add_sum;
                alu_c = add_c;
                // Overflow: like-signed operands producing an opposite-signed sum.
                alu_v = (alu_a[DATA_W-1] == alu_b[DATA_W-1]) &&
                        (add_sum[DATA_W-1] != alu_a[DATA_W-1]);
            end
            FS_XOR: alu_f = alu_a ^ alu_b;
            FS_SHL: alu_f = alu_b << alu_a[5:0];
            FS_SHR: alu_f = alu_b >> alu_a[5:0];
            default: alu_f = '0;
        endcase
    end

    always_comb begin
        status       = '0;
        status[ST_V] = alu_v;
        status[ST_C] = alu_c;
        status[ST_N] = alu_f[DATA_W-1];
        status[ST_Z] = (alu_f == '0);
    end

    // RAM: only the low address bits of F are decoded; no reset of contents.
    logic [DATA_W-1:0]     mem_q [MEM_WORDS];
    logic [MEM_ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0]     mem_rd_dat;
    logic                  mem_we;

    assign mem_addr   = alu_f[MEM_ADDR_W-1:0];
    // Without F on A the address bus floats, so reads return 0 and writes are dropped.
    assign mem_rd_dat = (readEn && triSelFtoA) ? mem_q[mem_addr] : '0;
    assign mem_we     = writeEn && triSelFtoA && !reset;

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem_q[mem_addr] <= bus_dat;
        end
    end

    // D bus: control guarantees at most one driver, so a priority mux models it.
    always_comb begin
        bus_dat = '0;
        bus_vld = 1'b0;
        if (triSelFtoD) begin
            bus_dat = alu_f;
            bus_vld = 1'b1;
        end else if (triSelBtoD) begin
            bus_dat = rb_dat;
            bus_vld = 1'b1;
        end else if (triSelOuttoD) begin
            bus_dat = mem_rd_dat;
            bus_vld = 1'b1;
        end
    end

    assign D = bus_vld ? bus_dat : {DATA_W{1'bz}};

endmodule

// File: tb/tb_datapath_with_memory.sv
module tb_datapath_with_memory;

    logic        clock = 1'b0;
    logic        reset;
    logic [63:0] k;
    logic [4:0]  SA, SB, DA, FS;
    logic        W, selbork, Cin;
    logic        triSelBtoD, triSelFtoD, triSelFtoA, triSelOuttoD;
    logic        writeEn, readEn;
    wire  [63:0] D;
    logic [3:0]  status;
    logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7;

    int err_cnt = 0;
    int chk_cnt = 0;

    localparam logic [63:0] MAXPOS = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINNEG = 64'h8000_0000_0000_0000;

    always #5 clock = ~clock;

    datapath_with_memory #(.MEM_WORDS(256)) dut (
        .clock(clock), .reset(reset), .k(k), .SA(SA), .SB(SB), .DA(DA), .W(W),
        .selbork(selbork), .FS(FS), .Cin(Cin),
        .triSelBtoD(triSelBtoD), .triSelFtoD(triSelFtoD), .triSelFtoA(triSelFtoA),
        .triSelOuttoD(triSelOuttoD), .writeEn(writeEn), .readEn(readEn),
        .D(D), .status(status),
        .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6), .r7(r7)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        k = '0; SA = '0; SB = '0; DA = '0; FS = '0;
        W = 0; selbork = 0; Cin = 0;
        triSelBtoD = 0; triSelFtoD = 0; triSelFtoA = 0; triSelOuttoD = 0;
        writeEn = 0; readEn = 0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Write an immediate into a register via R31 | k on the F path.
    task automatic load_imm(input logic [4:0] rd, input logic [63:0] val);
        idle();
        k = val; SA = 5'd31; selbork = 1; FS = 5'b00100;
        triSelFtoD = 1; W = 1; DA = rd;
        step();
        idle();
    endtask

    // Read mem[addr] onto D using F = R31 | k as the address.
    task automatic mem_read(input logic [63:0] addr);
        idle();
        k = addr; SA = 5'd31; selbork = 1; FS = 5'b00100;
        triSelFtoA = 1; readEn = 1; triSelOuttoD = 1;
        #1;
    endtask

    initial begin
        idle();
        reset = 1;
        step();
        check("rst_r0", {48'd0, r0}, 64'd0);
        check("rst_r3", {48'd0, r3}, 64'd0);
        reset = 0;

        // Immediate OR into R3
        k = 64'd7; SA = 5'd31; selbork = 1; FS = 5'b00100;
        triSelFtoD = 1; W = 1; DA = 5'd3;
        #1;
        check("or_d", D, 64'd7);
        check("or_status", {60'd0, status}, 64'h0);
        step();
        check("or_r3", {48'd0, r3}, 64'd7);

        // Store R3 to mem[7]
        idle();
        SA = 5'd31; SB = 5'd3; FS = 5'b00100;
        triSelBtoD = 1; triSelFtoA = 1; writeEn = 1;
        #1;
        check("st_d", D, 64'd7);
        step();
        check("st_r3", {48'd0, r3}, 64'd7);
        check("st_r2", {48'd0, r2}, 64'd0);

        // Load mem[7] into R2
        idle();
        SA = 5'd31; SB = 5'd3; FS = 5'b00100;
        triSelOuttoD = 1; triSelFtoA = 1; readEn = 1; DA = 5'd2; W = 1;
        #1;
        check("ld_d", D, 64'd7);
        step();
        check("ld_r2", {48'd0, r2}, 64'd7);

        // Read with readEn low returns zero
        mem_read(64'd7);
        readEn = 0;
        #1;
        check("rd_dis_d", D, 64'd0);

        // ADD overflow
        load_imm(5'd1, MAXPOS);
        check("imm_r1", {48'd0, r1}, 64'hFFFF);
        SA = 5'd1; k = 64'd1; selbork = 1; FS = 5'b01000; Cin = 0; triSelFtoD = 1;
        #1;
        check("add_d", D, MINNEG);
        check("add_status", {60'd0, status}, 64'b1010);
        // ~A + ~B + 1 = 0x7FFF..FF with carry and overflow
        FS = 5'b01011; Cin = 1;
        #1;
        check("nn_d", D, MAXPOS);
        check("nn_status", {60'd0, status}, 64'b1100);
        // B - A with equal operands
        FS = 5'b01001; k = MAXPOS;
        #1;
        check("sub_d", D, 64'd0);
        check("sub_status", {60'd0, status}, 64'b0101);

        // Logic / shift ops, R2=7, R3=7
        idle(); triSelFtoD = 1; selbork = 1;
        SA = 5'd2; k = 64'd1;     FS = 5'b10000; #1; check("shl_d", D, 64'h80);
        SA = 5'd2; k = 64'h100;   FS = 5'b10100; #1; check("shr_d", D, 64'h2);
        SA = 5'd3; k = 64'd5;     FS = 5'b01100; #1; check("xor_d", D, 64'h2);
        SA = 5'd3; k = 64'hC;     FS = 5'b00000; #1; check("and_d", D, 64'h4);
        SA = 5'd3; k = 64'hC;     FS = 5'b00001; #1; check("andna_d", D, 64'h8);
        SA = 5'd3; k = 64'hFF;    FS = 5'b11000; #1;
        check("zero_d", D, 64'd0);
        check("zero_status", {60'd0, status}, 64'b0001);

        // Writes to R31 are ignored
        load_imm(5'd31, 64'd5);
        SB = 5'd31; triSelBtoD = 1;
        #1;
        check("r31_d", D, 64'd0);

        // RAM write with A undriven is dropped
        idle();
        SA = 5'd31; SB = 5'd1; k = 64'd7; selbork = 1; FS = 5'b00100;
        triSelBtoD = 1; writeEn = 1;
        step();
        mem_read(64'd7);
        check("noa_mem7", D, 64'd7);

        // Reset beats W and blocks RAM writes
        load_imm(5'd0, 64'h1234);
        check("pre_r0", {48'd0, r0}, 64'h1234);
        idle();
        reset = 1; W = 1; DA = 5'd4;
        SA = 5'd31; SB = 5'd1; k = 64'd7; selbork = 1; FS = 5'b00100;
        triSelBtoD = 1; triSelFtoA = 1; writeEn = 1;
        #1;
        check("rst_bus_d", D, MAXPOS);
        step();
        reset = 0;
        check("rst2_r0", {48'd0, r0}, 64'd0);
        check("rst2_r1", {48'd0, r1}, 64'd0);
        check("rst2_r2", {48'd0, r2}, 64'd0);
        check("rst2_r3", {48'd0, r3}, 64'd0);
        check("rst2_r4", {48'd0, r4}, 64'd0);
        check("rst2_r5_7", {16'd0, r5, r6, r7}, 64'd0);
        mem_read(64'd7);
        check("rst_mem7", D, 64'd7);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/datapath_with_memory.md
Name: datapath_with_memory

Overview:
- 64-bit LEGv8-style datapath: 32x64 register file, 5-bit-function ALU, data RAM, and a shared tri-state data bus D.
- Sources onto D: register B output, ALU result F, memory read data. D is written back to the register file.
- The ALU result also drives the memory address bus A.
- Debug ports expose the low 16 bits of R0..R7. Intended as the execution core under a later control unit.

Parameters:
- MEM_WORDS, 256, number of 64-bit RAM words; address = A[7:0], upper address bits ignored.

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- k  in  64  immediate constant
- SA  in  5  register read address A
- SB  in  5  register read address B
- DA  in  5  register write address
- W  in  1  register write enable
- selbork  in  1  ALU B-operand select: 1 = k, 0 = register B
- FS  in  5  ALU function select
- Cin  in  1  ALU carry in
- triSelBtoD  in  1  drive register B onto D
- triSelFtoD  in  1  drive F onto D
- triSelFtoA  in  1  drive F onto address bus A
- triSelOuttoD  in  1  drive memory read data onto D
- writeEn  in  1  RAM write enable
- readEn  in  1  RAM read enable
- D  out  64  shared data bus; tri-state, Z when undriven
- status  out  4  {V,C,N,Z} of current ALU result
- r0..r7  out  16 each  R0[15:0]..R7[15:0], combinational

Behaviour:
Register file
- 32x64 registers with two combinational read ports: RA=R[SA], RB=R[SB].
- R31 always reads 0; writes to R31 are ignored.
- On rising edge: if reset, R0..R30 <= 0; else if W, R[DA] <= D.
- If D is Z/undriven when W=1, the stored value is undefined.

ALU (combinational)
- Operand A = RA. Operand B = selbork ? k : RB.
- FS[0] inverts A; FS[1] inverts B.
- FS[4:2] selects the operation:
  - 000 AND
  - 001 OR
  - 010 ADD (A+B+Cin)
  - 011 XOR
  - 100 shift left B by A[5:0]
  - 101 shift right logical B by A[5:0]
  - 11x result 0
- status: Z = (F==0); N = F[63]; C = carry out of the adder (0 for non-add ops); V = signed overflow of the add (0 for non-add ops).

Buses
- D = F if triSelFtoD; RB if triSelBtoD; memory data if triSelOuttoD; otherwise Z.
- Control must assert at most one D driver; multiple drivers give undefined contention.
- A = F when triSelFtoA, else undriven. When A is undriven, RAM writes are suppressed and read data is 0.

RAM
- Write: synchronous on rising edge; if writeEn && triSelFtoA && !reset, mem[A[7:0]] <= D.
- Read: asynchronous; read data = mem[A[7:0]] when readEn, else 0. Drives D only with triSelOuttoD.
- A read and a write to the same address in the same cycle returns the old data.
- RAM contents are not cleared by reset. Reset does not affect the D or A drivers.

Latency and outputs
- Combinational paths: registers to ALU to D/A/status, and memory to D.
- Register and memory writes take effect at the next rising edge.
- During and after reset: r0..r7 = 0, status reflects the current ALU inputs, D follows the tri-state selects.

Decomposition:
- Shared package:
  - Width constants: DATA_W = 64, REG_ADDR_W = 5, FS_W = 5.
  - FS op enum: AND, OR, ADD, XOR, SHL, SHR.
  - Status bit indices: V = 3, C = 2, N = 1, Z = 0.
- Natural sub-module: register_file (32x64, R31 zero, sync reset). ALU and RAM stay inline.

Test Plan:
- Reset then immediate OR: reset=1 for one cycle; then k=7, SA=31, selbork=1, FS=00100, triSelFtoD=1, W=1, DA=3 -> D=7 during the cycle; after the edge r3=7, status Z=0.
- Store: SA=31, SB=3, selbork=0, FS=00100, triSelBtoD=1, triSelFtoA=1, writeEn=1, W=0 -> A=7, D=7; after the edge mem[7]=7, registers unchanged.
- Load: same SA/SB/FS, triSelOuttoD=1, triSelFtoA=1, readEn=1, DA=2, W=1 -> D=7 combinationally; after the edge r2=7.
- ADD/status: R1=0x7FFF_FFFF_FFFF_FFFF via immediate, SA=1, k=1, selbork=1, FS=01000, Cin=0 -> F=0x8000_0000_0000_0000, N=1, V=1, C=0, Z=0. Same with FS=01011 (A inverted, B inverted, Cin=1) checks subtraction; result on B-A equal gives Z=1, C=1.
- R31/bus rules: W=1, DA=31 with D=5 -> R31 still reads 0. All tri-selects 0 -> D=Z. writeEn=1 with triSelFtoA=0 -> memory unchanged.
- Reset mid-operation: with r0..r7 nonzero, assert reset together with W=1 -> next edge all registers 0 (reset wins over W); mem[7] still 7.
